// File: rtl/sync_fifo_param.sv
// ----------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO with occupancy count, programmable
//   almost-full / almost-empty thresholds, overflow / underflow error pulses
//   and a selectable first-word-fall-through read mode.
//
// Parameters
//   DATA_W   : data word width (>= 1)
//   DEPTH    : number of entries (power of two, >= 2)
//   AF_LEVEL : almost_full when count >= AF_LEVEL
//   AE_LEVEL : almost_empty when count <= AE_LEVEL
//   FWFT     : 0 = registered read (latency 1), 1 = first-word-fall-through
//
// Ports
//   i_clk            rising-edge clock
//   i_rst            asynchronous active-high reset
//   i_wr_en          write request
//   i_data_in        write data
//   i_rd_en          read request (pop/acknowledge in FWFT mode)
//   o_data_out       read data
//   o_full           count == DEPTH
//   o_empty          count == 0
//   o_almost_full    count >= AF_LEVEL
//   o_almost_empty   count <= AE_LEVEL
//   o_count          current occupancy
//   o_overflow       one-cycle pulse after a write to a full FIFO
//   o_underflow      one-cycle pulse after a read from an empty FIFO
// ----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_en,
  input  logic [DATA_W-1:0]          i_data_in,
  input  logic                       i_rd_en,
  output logic [DATA_W-1:0]          o_data_out,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_almost_full,
  output logic                       o_almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] C_AE    = CNT_W'(AE_LEVEL);
  localparam logic             AF_RST  = (AF_LEVEL == 0);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_almost_full;
  logic             r_almost_empty;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Acceptance uses the registered (pre-edge) flags only, so a same-cycle
  // read never frees space for a write and a same-cycle write never supplies
  // data for a read.
  assign w_wr_acc  = i_wr_en & ~r_full;
  assign w_rd_acc  = i_rd_en & ~r_empty;
  assign w_cnt_nxt = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_data_in;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= AF_RST;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count        <= w_cnt_nxt;
      // Flags come from the next count so they line up with o_count.
      r_full         <= (w_cnt_nxt == C_DEPTH);
      r_empty        <= (w_cnt_nxt == '0);
      r_almost_full  <= (w_cnt_nxt >= C_AF);
      r_almost_empty <= (w_cnt_nxt <= C_AE);
      r_overflow     <= i_wr_en & r_full;
      r_underflow    <= i_rd_en & r_empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is presented directly; forced to zero while empty so
      // reset visibly clears the output.
      assign o_data_out = r_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
      logic [DATA_W-1:0] r_data_out;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_data_out <= '0;
        end else if (w_rd_acc) begin
          r_data_out <= r_mem[r_rd_ptr];
        end
      end

      assign o_data_out = r_data_out;
    end
  endgenerate

  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_almost_full  = r_almost_full;
  assign o_almost_empty = r_almost_empty;
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule
